// File: rtl/digit_accumulator.sv
// digit_accumulator: keypad digit entry into packed BCD and binary operand.
// Operand is presented on a valid/ready handshake once entry is committed.
//
// Ports:
//   clk, rst_n       clock, async active-low reset
//   digit_code       keypad code (4'hF = 0, 1..9 = digits)
//   digit_valid      level, high while a key is held
//   commit, clear    single-cycle entry controls
//   operand_ready    consumer accepts the operand
//   operand_valid    operand presented
//   bcd_value        packed BCD, LSD in [3:0]
//   bin_value        binary equivalent
//   digit_count      significant digits held
//   overflow         sticky, a digit was dropped
//   bad_code         one-cycle pulse after an invalid press
module digit_accumulator #(
  parameter  int MAX_DIGITS = 4,
  parameter  int BIN_W      = 14,
  localparam int CW         = $clog2(MAX_DIGITS + 1),
  localparam int BW         = 4 * MAX_DIGITS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       digit_code,
  input  logic             digit_valid,
  input  logic             commit,
  input  logic             clear,
  input  logic             operand_ready,
  output logic             operand_valid,
  output logic [BW-1:0]    bcd_value,
  output logic [BIN_W-1:0] bin_value,
  output logic [CW-1:0]    digit_count,
  output logic             overflow,
  output logic             bad_code
);

  typedef enum logic [1:0] {
    IDLE,
    ENTRY,
    HOLD
  } state_t;

  state_t state;

  logic dv_q;
  logic block_q;
  logic press;
  logic code_ok;
  logic [3:0] dig;
  logic [BIN_W-1:0] bin_next;

  // block_q suppresses a key already held when reset released
  assign press = digit_valid & ~dv_q & ~block_q;

  always_comb begin
    code_ok = 1'b0;
    dig     = 4'd0;
    unique case (1'b1)
      (digit_code == 4'hF): begin
        code_ok = 1'b1;
        dig     = 4'd0;
      end
      (digit_code >= 4'd1 && digit_code <= 4'd9): begin
        code_ok = 1'b1;
        dig     = digit_code;
      end
      default: begin
        code_ok = 1'b0;
        dig     = 4'd0;
      end
    endcase
  end

  assign bin_next = bin_value * BIN_W'(10) + BIN_W'(dig);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      dv_q          <= 1'b0;
      block_q       <= 1'b1;
      operand_valid <= 1'b0;
      bcd_value     <= '0;
      bin_value     <= '0;
      digit_count   <= '0;
      overflow      <= 1'b0;
      bad_code      <= 1'b0;
    end else begin
      dv_q     <= digit_valid;
      block_q  <= block_q & digit_valid;
      bad_code <= 1'b0;
      if (clear) begin
        state         <= IDLE;
        operand_valid <= 1'b0;
        bcd_value     <= '0;
        bin_value     <= '0;
        digit_count   <= '0;
        overflow      <= 1'b0;
      end else begin
        unique case (state)
          IDLE, ENTRY: begin
            if (commit) begin
              state         <= HOLD;
              operand_valid <= 1'b1;
            end else if (press) begin
              if (!code_ok) begin
                bad_code <= 1'b1;
              end else if (state == IDLE) begin
                // leading zeros are swallowed
                if (dig != 4'd0) begin
                  state       <= ENTRY;
                  bcd_value   <= {{(BW-4){1'b0}}, dig};
                  bin_value   <= BIN_W'(dig);
                  digit_count <= CW'(1);
                end
              end else if (digit_count < CW'(MAX_DIGITS)) begin
                bcd_value   <= {bcd_value[BW-5:0], dig};
                bin_value   <= bin_next;
                digit_count <= digit_count + CW'(1);
              end else begin
                overflow <= 1'b1;
              end
            end
          end
          HOLD: begin
            if (operand_ready) begin
              state         <= IDLE;
              operand_valid <= 1'b0;
              bcd_value     <= '0;
              bin_value     <= '0;
              digit_count   <= '0;
              overflow      <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_digit_accumulator.sv
// tb_digit_accumulator: directed scoreboard bench for digit_accumulator.
// A decimal-value model predicts every output after each clocked step.
module tb_digit_accumulator;

  localparam int MD = 4;
  localparam int BN = 14;

  typedef struct packed {
    logic        ov;
    logic        ovf;
    logic        bad;
    logic [2:0]  cnt;
    logic [13:0] bin;
    logic [15:0] bcd;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  digit_code = 4'd0;
  logic        digit_valid = 1'b0;
  logic        commit = 1'b0;
  logic        clear = 1'b0;
  logic        operand_ready = 1'b0;
  logic        operand_valid;
  logic [15:0] bcd_value;
  logic [13:0] bin_value;
  logic [2:0]  digit_count;
  logic        overflow;
  logic        bad_code;

  always #5 clk = ~clk;

  digit_accumulator #(
    .MAX_DIGITS(MD),
    .BIN_W(BN)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .digit_code(digit_code),
    .digit_valid(digit_valid),
    .commit(commit),
    .clear(clear),
    .operand_ready(operand_ready),
    .operand_valid(operand_valid),
    .bcd_value(bcd_value),
    .bin_value(bin_value),
    .digit_count(digit_count),
    .overflow(overflow),
    .bad_code(bad_code)
  );

  int vectors = 0;
  int miscompares = 0;

  int m_val;
  int m_cnt;
  bit m_ovf, m_ov, m_bad, m_pdv, m_blk;
  exp_t q[$];

  function automatic exp_t model_out();
    exp_t e;
    int v;
    v = m_val;
    e.bcd = '0;
    for (int i = 0; i < MD; i++) begin
      e.bcd[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    e.bin = 14'(m_val % (1 << BN));
    e.cnt = 3'(m_cnt);
    e.ov  = m_ov;
    e.ovf = m_ovf;
    e.bad = m_bad;
    return e;
  endfunction

  function automatic exp_t dut_out();
    exp_t e;
    e = {operand_valid, overflow, bad_code,
         digit_count, bin_value, bcd_value};
    return e;
  endfunction

  task automatic model_reset();
    m_val = 0;
    m_cnt = 0;
    m_ovf = 0;
    m_ov  = 0;
    m_bad = 0;
    m_pdv = 0;
    m_blk = 1;
  endtask

  task automatic model_clock(logic dv, logic [3:0] code,
                             logic cm, logic cl, logic rdy);
    bit pr;
    bit ok;
    int d;
    pr = dv && !m_pdv && !m_blk;
    ok = (code == 4'hF) || (code >= 4'd1 && code <= 4'd9);
    d  = (code == 4'hF) ? 0 : int'(code);
    m_bad = 0;
    if (cl) begin
      m_val = 0; m_cnt = 0; m_ovf = 0; m_ov = 0;
    end else if (m_ov) begin
      if (rdy) begin
        m_val = 0; m_cnt = 0; m_ovf = 0; m_ov = 0;
      end
    end else if (cm) begin
      m_ov = 1;
    end else if (pr) begin
      if (!ok) m_bad = 1;
      else if (m_cnt == 0) begin
        if (d != 0) begin
          m_val = d;
          m_cnt = 1;
        end
      end else if (m_cnt < MD) begin
        m_val = m_val * 10 + d;
        m_cnt++;
      end else m_ovf = 1;
    end
    m_blk = m_blk && dv;
    m_pdv = dv;
  endtask

  task automatic check(string tag, exp_t obs, exp_t exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(string tag, logic dv, logic [3:0] code,
                      logic cm = 0, logic cl = 0, logic rdy = 0);
    @(negedge clk);
    digit_valid   = dv;
    digit_code    = code;
    commit        = cm;
    clear         = cl;
    operand_ready = rdy;
    model_clock(dv, code, cm, cl, rdy);
    q.push_back(model_out());
    @(posedge clk);
    #1;
    check(tag, dut_out(), q.pop_front());
  endtask

  task automatic key(string tag, logic [3:0] code);
    step(tag, 1'b1, code);
    step({tag, "_rel"}, 1'b0, code);
  endtask

  initial begin
    model_reset();
    #12;
    check("reset_hold", dut_out(), model_out());
    @(negedge clk);
    rst_n = 1'b1;
    step("idle", 0, 4'h0);

    // leading zero, 1, 2, trailing zero, commit
    key("k0_lead", 4'hF);
    key("k1", 4'h1);
    key("k2", 4'h2);
    key("k0", 4'hF);
    step("commit120", 0, 4'h0, 1);
    step("hs120", 0, 4'h0, 0, 0, 1);

    // overflow then ready held through commit
    repeat (4) key("k9", 4'h9);
    key("k5_ovf", 4'h5);
    step("commit9999", 0, 4'h0, 1, 0, 1);
    step("hs9999", 0, 4'h0, 0, 0, 1);
    step("idle9999", 0, 4'h0, 0, 0, 1);

    // held key gives one press; invalid code pulses once
    repeat (5) step("hold7", 1, 4'h7);
    step("rel7", 0, 4'h7);
    step("badC", 1, 4'hC);
    step("badC_rel", 0, 4'hC);
    step("badC_gone", 0, 4'h0);
    key("k3", 4'h3);

    // press with commit is dropped
    step("press_commit", 1, 4'h4, 1);
    step("hold_rel", 0, 4'h4);
    for (int i = 0; i < 10; i++)
      step("hold_press", (i % 2) == 0, (i % 4 == 0) ? 4'hC : 4'h8);
    step("commit_in_hold", 0, 4'h0, 1);
    step("clear_commit", 0, 4'h0, 1, 1);

    // commit from idle presents zero
    step("commit_idle", 0, 4'h0, 1);
    step("hs_idle", 0, 4'h0, 0, 0, 1);

    // clear mid-entry, press with clear dropped
    key("k6", 4'h6);
    step("press_clear", 1, 4'h2, 0, 1);
    step("clr_rel", 0, 4'h0);
    key("k8", 4'h8);
    key("k1b", 4'h1);

    // async reset mid-entry with key held
    step("held5", 1, 4'h5);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("async_reset", dut_out(), model_out());
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) step("post_rst_held", 1, 4'h5);
    step("post_rst_rel", 0, 4'h5);
    key("k6_post", 4'h6);
    key("k7_post", 4'h7);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/digit_accumulator.md
DIGIT_ACCUMULATOR -- requirements
Module: digit_accumulator

Interface
REQ-001 Parameter: MAX_DIGITS, default 4, maximum number of decimal digits held in one operand.
REQ-002 Parameter: BIN_W, default 14, width of the binary operand; shall be at least ceil(log2(10^MAX_DIGITS)).
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; clears all state while low.
REQ-005 digit_code  input  4  keypad digit code: 4'b1111 = digit 0, 4'b0001..4'b1001 = digits 1..9, all other codes invalid.
REQ-006 digit_valid  input  1  level; high while a key is held and digit_code is meaningful.
REQ-007 commit  input  1  single-cycle request to close entry and present the operand.
REQ-008 clear  input  1  single-cycle request to discard the current entry.
REQ-009 operand_ready  input  1  downstream consumer accepts the presented operand.
REQ-010 operand_valid  output  1  operand presented and stable.
REQ-011 bcd_value  output  4*MAX_DIGITS  packed BCD of the entry; least significant digit in bits [3:0].
REQ-012 bin_value  output  BIN_W  binary equivalent of bcd_value.
REQ-013 digit_count  output  clog2(MAX_DIGITS+1)  number of significant digits held.
REQ-014 overflow  output  1  sticky; a digit was dropped because the entry was full.
REQ-015 bad_code  output  1  one-cycle pulse on an accepted key press that carries an invalid code.

Function
REQ-016 Key press = digit_valid high this cycle and low in the previous cycle, using one registered copy of digit_valid; holding the key shall produce exactly one press.
REQ-017 FSM states: IDLE (count 0), ENTRY (count >= 1), HOLD (operand_valid high).
REQ-018 IDLE, valid press of digits 1..9 -> ENTRY; bcd_value = d; bin_value = d; digit_count = 1.
REQ-019 IDLE, press of digit 0 -> leading zero; stay in IDLE; value and count unchanged.
REQ-020 ENTRY, valid press with count < MAX_DIGITS -> bcd_value shifted left 4 bits with d inserted in [3:0]; bin_value = bin_value*10 + d, truncated to BIN_W; count + 1.
REQ-021 ENTRY, valid press with count == MAX_DIGITS -> digit dropped; value unchanged; overflow set.
REQ-022 Invalid code on a press -> value and state unchanged; bad_code high for exactly the following cycle.
REQ-023 All updates from a press are visible one cycle after the press cycle.
REQ-024 commit in IDLE or ENTRY -> HOLD; operand_valid high from the next cycle; a commit in IDLE presents value 0.
REQ-025 HOLD: bcd_value, bin_value, digit_count and overflow are held stable; presses are ignored, with no bad_code and no overflow.
REQ-026 HOLD with operand_valid & operand_ready at a clock edge -> IDLE; values, count, overflow and operand_valid are all 0 after that edge.
REQ-027 operand_valid shall not drop in HOLD until the handshake completes.
REQ-028 clear in any state -> IDLE with all outputs 0 on the next cycle, including an operand pending in HOLD.
REQ-029 Priority in the same cycle: clear > commit > press; a press coincident with commit or clear is discarded.
REQ-030 commit while already in HOLD is ignored.

Reset
REQ-031 While reset is low, all outputs shall be 0, the FSM shall be in IDLE and the registered digit_valid shall be 0, independent of clk.
REQ-032 Reset asserted mid-entry or in HOLD discards the operand; after release, a digit_valid already high shall not count as a press until it goes low and then high again.

Verification
REQ-033 Press sequence 0,1,2,0 (codes 1111,0001,0010,1111), then commit -> bcd_value 16'h0120, bin_value 120, digit_count 3, operand_valid 1.
REQ-034 Press 9,9,9,9,5 -> bcd_value 16'h9999, bin_value 9999, overflow 1; operand_ready held high after commit -> IDLE with all outputs 0.
REQ-035 digit_valid held high for 5 cycles with code 0111 -> exactly one digit 7 accepted; code 1100 press -> bad_code pulse of 1 cycle, value unchanged.
REQ-036 Press in the same cycle as commit -> press discarded; clear and commit in the same cycle -> IDLE with operand_valid 0.
REQ-037 HOLD with operand_ready 0 for 10 cycles and presses applied -> operand_valid stays 1 and the values are unchanged.
REQ-038 Reset pulsed low mid-entry with digit_valid held high -> outputs 0 immediately; no digit accepted until digit_valid falls and rises again.
